// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - instruction-in / immediate-out handshake bundle for imm_gen_pipe
//
// Purpose: groups the input (instruction) and output (immediate) handshakes.
// Signals:
//   in_valid    producer -> block  instruction offered
//   in_ready    block -> producer  block can accept
//   in_instr    producer -> block  raw 32-bit instruction word
//   out_valid   block -> consumer  result available
//   out_ready   consumer -> block  consumer accepts
//   out_imm     block -> consumer  extended immediate, XLEN bits
//   out_fmt     block -> consumer  0=none 1=I 2=S 3=B 4=U 5=J 6=Z
//   out_illegal block -> consumer  opcode not recognised
// Modports: master = producer/consumer side, slave = imm_gen_pipe.

interface imm_gen_pipe_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_imm;
   logic [2:0]      out_fmt;
   logic            out_illegal;

   modport master (
      output in_valid, in_instr, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_illegal
   );

   modport slave (
      input  in_valid, in_instr, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_illegal
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - RISC-V immediate decoder with skid-buffered valid/ready pipeline
//
// Purpose: decodes the immediate of each accepted instruction word, classifies
// its format and flags unknown opcodes. Results sit in a main register M with a
// one-entry skid register S behind it, so in_ready can be a plain register.
// Optional feature macro: IMM_GEN_ZICSR_EN (SYSTEM with funct3[2]=1 -> fmt Z,
// zero-extended inst[19:15]); when undefined every SYSTEM word decodes as I.
// Ports:
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   bus           imm_gen_pipe_if.slave handshake bundle
//   illegal_count saturating count of accepted illegal words (CNT_W bits)

module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   imm_gen_pipe_if.slave    bus,
   output logic [CNT_W-1:0] illegal_count
);

   localparam logic [2:0] FMT_NONE = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMM_GEN_ZICSR_EN
   localparam logic [2:0] FMT_Z    = 3'd6;
`endif

   logic [31:0]     w_i;
   logic [31:0]     w_imm32;
   logic [XLEN-1:0] w_imm;
   logic [2:0]      w_fmt;
   logic            w_ill;
   logic            w_acc;
   logic            w_m_load;
   logic            w_s_valid_nxt;

   logic            r_m_valid;
   logic [XLEN-1:0] r_m_imm;
   logic [2:0]      r_m_fmt;
   logic            r_m_ill;
   logic            r_s_valid;
   logic [XLEN-1:0] r_s_imm;
   logic [2:0]      r_s_fmt;
   logic            r_s_ill;
   logic            r_in_ready;
   logic [CNT_W-1:0] r_cnt;

   assign w_i = bus.in_instr;

   // Every format is built as a 32-bit value whose bit 31 is inst[31] (or 0
   // for zimm), so one signed cast extends all of them to XLEN.
   always_comb begin
      w_imm32 = 32'd0;
      w_fmt   = FMT_NONE;
      w_ill   = 1'b0;
      if (w_i[1:0] != 2'b11) begin
         w_ill = 1'b1;
      end else begin
         case (w_i[6:0])
            7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: begin
               w_imm32 = {{20{w_i[31]}}, w_i[31:20]};
               w_fmt   = FMT_I;
            end
            7'b1110011: begin
`ifdef IMM_GEN_ZICSR_EN
               if (w_i[14]) begin
                  w_imm32 = {27'd0, w_i[19:15]};
                  w_fmt   = FMT_Z;
               end else begin
                  w_imm32 = {{20{w_i[31]}}, w_i[31:20]};
                  w_fmt   = FMT_I;
               end
`else
               w_imm32 = {{20{w_i[31]}}, w_i[31:20]};
               w_fmt   = FMT_I;
`endif
            end
            7'b0011011: begin
               if (XLEN == 64) begin
                  w_imm32 = {{20{w_i[31]}}, w_i[31:20]};
                  w_fmt   = FMT_I;
               end else begin
                  w_ill = 1'b1;
               end
            end
            7'b0100011: begin
               w_imm32 = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
               w_fmt   = FMT_S;
            end
            7'b1100011: begin
               w_imm32 = {{20{w_i[31]}}, w_i[7], w_i[30:25], w_i[11:8], 1'b0};
               w_fmt   = FMT_B;
            end
            7'b0110111, 7'b0010111: begin
               w_imm32 = {w_i[31:12], 12'd0};
               w_fmt   = FMT_U;
            end
            7'b1101111: begin
               w_imm32 = {{12{w_i[31]}}, w_i[19:12], w_i[20], w_i[30:21], 1'b0};
               w_fmt   = FMT_J;
            end
            7'b0110011: begin
               w_fmt = FMT_NONE;
            end
            default: begin
               w_ill = 1'b1;
            end
         endcase
      end
   end

   assign w_imm = XLEN'($signed(w_imm32));

   assign w_acc    = bus.in_valid && r_in_ready;
   // M may be (re)loaded whenever it is empty or its result leaves this cycle.
   assign w_m_load = !r_m_valid || bus.out_ready;
   // S only fills when M is stuck; it always empties into M on the next load.
   // While S is full in_ready is low, so S and a new word never compete for M.
   assign w_s_valid_nxt = w_m_load ? 1'b0 : (r_s_valid || w_acc);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_m_valid  <= 1'b0;
         r_m_imm    <= '0;
         r_m_fmt    <= FMT_NONE;
         r_m_ill    <= 1'b0;
         r_s_valid  <= 1'b0;
         r_s_imm    <= '0;
         r_s_fmt    <= FMT_NONE;
         r_s_ill    <= 1'b0;
         r_in_ready <= 1'b1;
         r_cnt      <= '0;
      end else begin
         if (w_m_load) begin
            r_m_valid <= r_s_valid || w_acc;
            if (r_s_valid) begin
               r_m_imm <= r_s_imm;
               r_m_fmt <= r_s_fmt;
               r_m_ill <= r_s_ill;
            end else if (w_acc) begin
               r_m_imm <= w_imm;
               r_m_fmt <= w_fmt;
               r_m_ill <= w_ill;
            end
         end
         if (w_acc && !w_m_load) begin
            r_s_imm <= w_imm;
            r_s_fmt <= w_fmt;
            r_s_ill <= w_ill;
         end
         r_s_valid  <= w_s_valid_nxt;
         r_in_ready <= !w_s_valid_nxt;
         if (w_acc && w_ill && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign bus.in_ready    = r_in_ready;
   assign bus.out_valid   = r_m_valid;
   assign bus.out_imm     = r_m_imm;
   assign bus.out_fmt     = r_m_fmt;
   assign bus.out_illegal = r_m_ill;
   assign illegal_count   = r_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - scoreboard testbench for imm_gen_pipe (XLEN=32, CNT_W=8)

module tb_imm_gen_pipe;

   typedef struct packed {
      logic [31:0] imm;
      logic [2:0]  fmt;
      logic        ill;
   } exp_t;

   logic       clk;
   logic       reset_n;
   logic [7:0] illegal_count;
   exp_t       sb[$];
   int         n_checks;
   int         n_fail;

   imm_gen_pipe_if #(.XLEN(32)) bus ();

   imm_gen_pipe #(.XLEN(32), .CNT_W(8)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .bus           (bus),
      .illegal_count (illegal_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [31:0] ins, input logic [31:0] imm,
                       input logic [2:0] fmt, input logic ill);
      bit done;
      exp_t e;
      done = 1'b0;
      e.imm = imm;
      e.fmt = fmt;
      e.ill = ill;
      bus.in_valid = 1'b1;
      bus.in_instr = ins;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            sb.push_back(e);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      check("send_accepted", 64'(done), 64'd1);
   endtask

   // Monitor: the front of the queue must match whatever M presents, on every
   // cycle it is valid (covers stability under stall); popped on transfer.
   always @(negedge clk) begin
      if (reset_n && bus.out_valid) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got imm 0x%0h with empty scoreboard", bus.out_imm);
         end else begin
            check("out_imm", 64'(bus.out_imm), 64'(sb[0].imm));
            check("out_fmt", 64'(bus.out_fmt), 64'(sb[0].fmt));
            check("out_illegal", 64'(bus.out_illegal), 64'(sb[0].ill));
            if (bus.out_ready) void'(sb.pop_front());
         end
      end
   end

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      reset_n       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_instr  = 32'd0;
      bus.out_ready = 1'b0;
      #12;
      check("reset_out_valid", 64'(bus.out_valid), 64'd0);
      check("reset_in_ready", 64'(bus.in_ready), 64'd1);
      check("reset_count", 64'(illegal_count), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // directed decode vectors, consumer always ready
      bus.out_ready = 1'b1;
      send(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);
      check("latency_one_cycle", 64'(bus.out_valid), 64'd1);
      send(32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0);
      send(32'h123452B7, 32'h12345000, 3'd4, 1'b0);
      send(32'hFE512C23, 32'hFFFFFFF8, 3'd2, 1'b0);
      send(32'h0080006F, 32'h00000008, 3'd5, 1'b0);
      send(32'h002081B3, 32'h00000000, 3'd0, 1'b0);
      send(32'h0010009B, 32'h00000000, 3'd0, 1'b1);
      send(32'h00000001, 32'h00000000, 3'd0, 1'b1);
`ifdef IMM_GEN_ZICSR_EN
      send(32'h3002D073, 32'h00000005, 3'd6, 1'b0);
`else
      send(32'h3002D073, 32'h00000300, 3'd1, 1'b0);
`endif
      repeat (3) @(posedge clk);
      #1;
      check("count_after_directed", 64'(illegal_count), 64'd2);

      // backpressure: two fit (M and S), third is held off
      bus.out_ready = 1'b0;
      send(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);
      send(32'h123452B7, 32'h12345000, 3'd4, 1'b0);
      @(negedge clk);
      check("full_in_ready", 64'(bus.in_ready), 64'd0);
      check("full_out_valid", 64'(bus.out_valid), 64'd1);
      fork
         begin
            repeat (3) @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
         send(32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0);
      join
      repeat (4) @(posedge clk);
      #1;
      check("backpressure_drained", 64'(sb.size()), 64'd0);

      // illegal counter saturation
      for (int k = 0; k < 300; k++) send(32'h00000000, 32'h0, 3'd0, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check("count_saturated", 64'(illegal_count), 64'd255);

      // asynchronous reset with M and S full
      bus.out_ready = 1'b0;
      send(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);
      send(32'h00000000, 32'h0, 3'd0, 1'b1);
      #2;
      reset_n = 1'b0;
      sb.delete();
      #1;
      check("async_out_valid", 64'(bus.out_valid), 64'd0);
      check("async_in_ready", 64'(bus.in_ready), 64'd1);
      check("async_count", 64'(illegal_count), 64'd0);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_instr  = 32'h123452B7;
      sb.push_back('{imm: 32'h12345000, fmt: 3'd4, ill: 1'b0});
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("first_edge_accept", 64'(bus.out_valid), 64'd1);
      repeat (4) @(posedge clk);
      #1;
      check("final_drained", 64'(sb.size()), 64'd0);
      check("final_count", 64'(illegal_count), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate output width; legal values 32 or 64.
REQ-002 SHALL have parameter CNT_W, default 8, width of the illegal-instruction counter.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  instruction offered.
REQ-006 SHALL have port in_ready  output  1  block can accept.
REQ-007 SHALL have port in_instr  input  32  raw instruction word.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts.
REQ-010 SHALL have port out_imm  output  XLEN  sign- or zero-extended immediate.
REQ-011 SHALL have port out_fmt  output  3  0=none, 1=I, 2=S, 3=B, 4=U, 5=J, 6=Z (CSR zimm).
REQ-012 SHALL have port out_illegal  output  1  opcode not recognised.
REQ-013 SHALL have port illegal_count  output  CNT_W  saturating count of accepted illegal words.

Function
REQ-014 SHALL accept a word when in_valid && in_ready, and transfer a result when out_valid && out_ready.
REQ-015 SHALL hold results in a main register M and a one-entry skid register S; in_ready = !S.valid, driven from a register.
REQ-016 SHALL present an accepted word's result at the outputs one cycle after acceptance when M is empty or is draining in the same cycle.
REQ-017 SHALL, on acceptance while M is full and not draining, place the result in S; on the next M drain, S SHALL move to M and S SHALL empty.
REQ-018 SHALL sustain one result per cycle while out_ready stays high, and SHALL preserve result order.
REQ-019 SHALL hold out_* stable while out_valid && !out_ready.
REQ-020 SHALL decode imm per RISC-V base: I={inst[31:20]}; S={inst[31:25],inst[11:7]}; B={inst[31],inst[7],inst[30:25],inst[11:8],0}; U={inst[31:12],12'b0}; J={inst[31],inst[19:12],inst[20],inst[30:21],0}; all sign-extended from inst[31] to XLEN.
REQ-021 SHALL map opcodes: LOAD 0000011, OP-IMM 0010011, JALR 1100111, FENCE 0001111, SYSTEM 1110011 -> I; STORE 0100011 -> S; BRANCH 1100011 -> B; LUI 0110111, AUIPC 0010111 -> U; JAL 1101111 -> J; OP 0110011 -> none, imm 0, legal.
REQ-022 SHALL treat OP-IMM-32 0011011 as I when XLEN=64 and illegal when XLEN=32.
REQ-023 SHALL flag illegal (imm 0, fmt 0, out_illegal 1) for any other opcode or inst[1:0] != 2'b11.
REQ-024 SHALL increment illegal_count on acceptance of an illegal word, saturating at 2^CNT_W-1, never wrapping.

Reset
REQ-025 SHALL, on reset_n low, asynchronously clear M.valid, S.valid, out_imm, out_fmt, out_illegal and illegal_count to 0, and drive in_ready to 1.
REQ-026 SHALL discard in-flight results when reset is asserted mid-stream, and SHALL accept on the first rising edge after reset_n deasserts.

Configuration
REQ-027 SHALL, with IMM_GEN_ZICSR_EN defined, decode SYSTEM with funct3[2]=1 as fmt Z: imm = zero-extended inst[19:15].
REQ-028 SHALL, without IMM_GEN_ZICSR_EN, decode all SYSTEM words as I type and SHALL never produce fmt 6.

Verification
REQ-029 SHALL cover: 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_imm=0xFFFFFFFF, fmt=1; XLEN=64 -> 0xFFFFFFFFFFFFFFFF.
REQ-030 SHALL cover: 0xFE000EE3 (beq -4) -> out_imm=0xFFFFFFFC, fmt=3; 0x123452B7 (lui) -> 0x12345000, fmt=4.
REQ-031 SHALL cover: three back-to-back words with out_ready=0 -> two accepted, in_ready=0 on the third; out_ready=1 -> all three out in order, none lost.
REQ-032 SHALL cover: 300 accepted words of 0x00000000, CNT_W=8 -> out_illegal=1 each, illegal_count stops at 255.
REQ-033 SHALL cover: 0x3002D073 (csrrwi) -> with macro imm=5, fmt=6; without macro imm=0x00000300, fmt=1.
REQ-034 SHALL cover: reset_n pulsed low with M and S full -> out_valid=0, in_ready=1, illegal_count=0 immediately, without waiting for a clock edge.
